// File: rtl/booth_multiplier_param.sv
`default_nettype none
// ============================================================================
// Module   : booth_multiplier_param
// Brief    : Width-generic sequential radix-4 Booth multiplier, signed/unsigned,
//            with op_start / op_clear / op_done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module booth_multiplier_param #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int W2 = WIDTH + 2;
    localparam int HW = W2 + 2;
    localparam int N  = W2 / 2;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [W2-1:0]        a_q, a_d;
    logic [HW-1:0]        hi_q, hi_d;
    logic [W2-1:0]        lo_q, lo_d;
    logic                 bm1_q, bm1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [HW-1:0]        w_a_ext;
    logic [HW-1:0]        w_a_x2;
    logic [HW-1:0]        w_pp;
    logic [HW-1:0]        w_sum;

    assign w_a_ext = {{2{a_q[W2-1]}}, a_q};
    assign w_a_x2  = {w_a_ext[HW-2:0], 1'b0};

    always_comb begin
        w_pp = '0;
        case ({lo_q[1], lo_q[0], bm1_q})
            3'b001, 3'b010: w_pp = w_a_ext;
            3'b011:         w_pp = w_a_x2;
            3'b100:         w_pp = HW'(0) - w_a_x2;
            3'b101, 3'b110: w_pp = HW'(0) - w_a_ext;
            default:        w_pp = '0;
        endcase
    end

    assign w_sum = hi_q + w_pp;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        bm1_d    = bm1_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (op_clear) begin
            state_d  = S_IDLE;
            a_d      = '0;
            hi_d     = '0;
            lo_d     = '0;
            bm1_d    = 1'b0;
            cnt_d    = '0;
            result_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_start) begin
                        // Extension to W2 bits lets one signed datapath serve both modes.
                        a_d      = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                               : {2'b00, multiplicand};
                        lo_d     = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                               : {2'b00, multiplier};
                        hi_d     = '0;
                        bm1_d    = 1'b0;
                        cnt_d    = '0;
                        result_d = '0;
                        state_d  = S_BUSY;
                    end
                end
                S_BUSY: begin
                    hi_d  = {{2{w_sum[HW-1]}}, w_sum[HW-1:2]};
                    lo_d  = {w_sum[1:0], lo_q[W2-1:2]};
                    bm1_d = lo_q[1];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        // Low 2*WIDTH bits of the shifted {hi, lo} product.
                        result_d = {w_sum[WIDTH-1:0], lo_q[W2-1:2]};
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            bm1_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            bm1_q    <= bm1_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy    = (state_q == S_BUSY);
    assign op_done = (state_q == S_DONE);
    assign result  = result_q;

endmodule
`default_nettype wire

// File: doc/booth_multiplier_param.md
# booth_multiplier_param

Parametrised, sequential radix-4 Booth multiplier. It is the width-generic, signed/unsigned successor to the fixed 64-bit radix-2 multiplier, and keeps the same op_start / op_clear / op_done handshake and full double-width result. Radix-4 recoding retires two multiplier bits per cycle, which roughly halves latency compared with the radix-2 block. It sits beside the ALU as a multi-cycle execution unit.

## Interface
- WIDTH, default 64: operand width. Must be even and ≥ 4.
- clk  input  1: clock; all state changes on the rising edge.
- reset  input  1: synchronous, active-high reset.
- op_start  input  1: level request to start; sampled only in IDLE.
- op_clear  input  1: synchronous abort/clear; honoured in every state.
- signed_mode  input  1: 1 = both operands two's complement; 0 = both unsigned. Latched at start.
- multiplicand  input  WIDTH: operand A; latched at start.
- multiplier  input  WIDTH: operand B; latched at start.
- busy  output  1: high while in BUSY.
- op_done  output  1: high while in DONE.
- result  output  2*WIDTH: product; 0 outside DONE.

## Operation
- Internal width is W2 = WIDTH+2.
  - Each operand is extended to W2 bits: sign-extended if signed_mode=1, zero-extended otherwise.
  - The extension lets a single radix-4 signed datapath serve both modes.
- Iteration count is N = W2/2 = WIDTH/2 + 1 (N = 33 for WIDTH = 64; N = 5 for WIDTH = 8).
- State machine has three states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - op_start=1 and op_clear=0: latch operands and mode, clear the accumulator, set count to 0, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, once per cycle:
  - Examine the bit triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1] = 0.
  - Select partial product 0, ±A or ±2A (A = extended multiplicand, sign-correct at W2+1 bits).
  - Add into the accumulator, then arithmetic-shift right by 2.
  - Increment count.
  - On the step where count reaches N-1: load the low 2*WIDTH bits of the product into result and go to DONE.
- DONE:
  - Hold result and op_done.
  - op_start staying high does not restart; a new operation needs op_clear followed by op_start.
- op_clear=1 in any state, next edge:
  - state becomes IDLE, result becomes 0, accumulator and count clear.
  - op_clear has priority over op_start in the same cycle.
- reset=1: identical effect to op_clear, and has priority over both op_clear and op_start.
- Result width rule: the exact product fits in 2*WIDTH bits in both modes, so there is no overflow and no saturation.
  - Signed: the result is the two's-complement 2*WIDTH-bit value.
  - Unsigned: the result is the plain binary value.
- Operand inputs may change freely after the start edge; they have no effect until the next start.

## Timing
- Reset values: busy=0, op_done=0, result=0, state=IDLE.
- Edge 0 samples op_start in IDLE; busy=1 after edge 0.
- Steps occur on edges 1..N.
- After edge N: busy=0, op_done=1, result valid.
- Latency is N clocks from the start edge to op_done high: 33 clocks for WIDTH=64.
- All outputs are registered; there are no combinational input-to-output paths.
- op_clear asserted for a single cycle mid-BUSY: busy and op_done are 0 after the next edge. If op_start is held high and op_clear has deasserted, a new operation starts on the following edge.
- Operand pairs that are both zero take the full N cycles; there is no early termination.

## Test plan
- WIDTH=64, signed, 5 × 3 → result 128'h…000F; op_done rises exactly 33 clocks after the start edge; busy is high for the whole interval.
- WIDTH=64, signed, 5 × 64'hFFFF_FFFF_FFFF_FFFD (−3) → result 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1. Same operands with signed_mode=0 → 128'h0000_0000_0000_0004_FFFF_FFFF_FFFF_FFF1.
- WIDTH=64, signed, 64'h8000_0000_0000_0000 × 64'h8000_0000_0000_0000 → 128'h4000_0000_0000_0000_0000_0000_0000_0000. Also: 0 × 7 → 0 and 7 × 0 → 0, each with op_done after 33 clocks.
- Abort: start 5 × 3, then assert op_clear for one cycle at clock 10 of BUSY.
  - Next edge: busy=0, op_done=0, result=0.
  - With op_start held high, the operation restarts and op_done comes 33 clocks after the restart edge with result 15.
  - op_clear and op_start high together in IDLE → stays IDLE.
- WIDTH=8 instance, signed, 8'h80 (−128) × 8'h7F (127) → 16'hC080 after 5 clocks. Unsigned 8'hFF × 8'hFF → 16'hFE01.
- Assert reset mid-BUSY and in DONE → all outputs 0 on the next edge. Holding op_start high in DONE with no op_clear → result unchanged and no restart for 50 clocks.
